// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Samples mid-bit using a counter timed from the synchronized start edge.
`timescale 1ns/1ps
module uart_rx #(
  parameter int BR       = 9600,
  parameter int CLK_RATE = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX_serial_in_bit,
  output logic [7:0] RX_data_out,
  output logic       RX_valid,
  output logic       RX_parity_err,
  output logic       RX_frame_err,
  output logic       RX_active
);

  localparam int N  = CLK_RATE / BR;
  localparam int H  = N / 2;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_sync2, r_prev;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_par_err, w_par_err_nxt;
  logic          w_fall, w_load;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= RX_serial_in_bit;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_par_err <= w_par_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_par_err_nxt = r_par_err;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_PARITY;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_PARITY: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt     = '0;
          w_par_err_nxt = ^{r_shift, r_sync2};
          w_state_nxt   = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        // The strobe cycle still counts as active; a start edge arriving
        // in that cycle is taken directly so zero-gap frames are not lost.
        if (RX_valid) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_fall ? S_START : S_IDLE;
        end else if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          w_load    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      RX_data_out   <= '0;
      RX_valid      <= 1'b0;
      RX_parity_err <= 1'b0;
      RX_frame_err  <= 1'b0;
    end else begin
      RX_valid <= w_load;
      if (w_load) begin
        RX_data_out   <= r_shift;
        RX_parity_err <= r_par_err;
        RX_frame_err  <= ~r_sync2;
      end
    end
  end

  always_comb RX_active = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx at N=16, H=8; received frames are compared
// against expectations derived directly from the frame contents and timing rules.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int N   = 16;
  localparam int H   = 8;
  localparam int LAT = 2 + H + 10 * N + 1;  // pin edge to RX_valid: 2 sync cycles + H+10N+1

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] RX_data_out;
  logic       RX_valid, RX_parity_err, RX_frame_err, RX_active;

  uart_rx #(.BR(10), .CLK_RATE(160)) dut (
    .clk(clk), .reset(reset), .RX_serial_in_bit(rx),
    .RX_data_out(RX_data_out), .RX_valid(RX_valid),
    .RX_parity_err(RX_parity_err), .RX_frame_err(RX_frame_err),
    .RX_active(RX_active)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [7:0]  d;
    logic        pe;
    logic        fe;
  } frm_t;

  frm_t obs_q[$];
  frm_t exp_q[$];
  logic [7:0] last_d  = '0;
  logic       last_pe = 1'b0;
  logic       last_fe = 1'b0;
  int tests = 0;
  int fails = 0;

  always @(negedge clk) begin : mon
    frm_t f;
    if (RX_valid) begin
      f.at = cyc; f.d = RX_data_out; f.pe = RX_parity_err; f.fe = RX_frame_err;
      obs_q.push_back(f);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    ticks(n);
  endtask

  // Drives one 11-bit frame; rst_bit >= 0 pulses reset mid-way through that bit.
  task automatic send(input logic [7:0] d, input logic par, input logic stop, input int rst_bit);
    logic [10:0] bits;
    int unsigned t0;
    frm_t        f;
    bits = {stop, par, d, 1'b0};
    t0   = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      if (i == rst_bit) begin
        ticks(8);
        reset = 1'b0;
        ticks(1);
        reset = 1'b1;
        chk("rst_data", RX_data_out, 0);
        chk("rst_valid", RX_valid, 0);
        chk("rst_pe", RX_parity_err, 0);
        chk("rst_fe", RX_frame_err, 0);
        chk("rst_active", RX_active, 0);
        ticks(7);
      end else begin
        ticks(16);
      end
    end
    if (rst_bit < 0) begin
      f.at = t0 + LAT; f.d = d; f.pe = (^d) ^ par; f.fe = ~stop;
      exp_q.push_back(f);
      last_d = f.d; last_pe = f.pe; last_fe = f.fe;
    end else begin
      last_d = '0; last_pe = 1'b0; last_fe = 1'b0;
    end
  endtask

  task automatic check_frames(input string tag);
    chk($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_%0d_data", tag, i), obs_q[i].d, exp_q[i].d);
      chk($sformatf("%s_%0d_pe", tag, i), obs_q[i].pe, exp_q[i].pe);
      chk($sformatf("%s_%0d_fe", tag, i), obs_q[i].fe, exp_q[i].fe);
      chk($sformatf("%s_%0d_cycle", tag, i), obs_q[i].at, exp_q[i].at);
    end
    chk($sformatf("%s_active", tag), RX_active, 0);
    chk($sformatf("%s_hold_d", tag), RX_data_out, last_d);
    chk($sformatf("%s_hold_pe", tag), RX_parity_err, last_pe);
    chk($sformatf("%s_hold_fe", tag), RX_frame_err, last_fe);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int unsigned t0;
    logic        prev_stop;
    logic        bp, bs;
    logic [7:0]  d;
    int          gap;

    reset = 1'b0;
    rx    = 1'b1;
    ticks(4);
    chk("reset_data", RX_data_out, 0);
    chk("reset_valid", RX_valid, 0);
    chk("reset_pe", RX_parity_err, 0);
    chk("reset_fe", RX_frame_err, 0);
    chk("reset_active", RX_active, 0);
    reset = 1'b1;
    idle(10);

    send(8'hA5, 1'b0, 1'b1, -1);
    idle(20);
    check_frames("a5");

    send(8'h01, 1'b0, 1'b1, -1);
    idle(10);
    check_frames("par_bad");
    send(8'h3C, 1'b0, 1'b1, -1);
    idle(10);
    check_frames("par_clear");

    send(8'h7E, 1'b0, 1'b0, -1);
    ticks(3 * N);
    check_frames("stop_bad_break");
    idle(20);
    send(8'h96, 1'b0, 1'b1, -1);
    idle(10);
    check_frames("after_break");

    rx = 1'b0;
    t0 = cyc;
    ticks(3);
    chk("glitch_act_t1", RX_active, 1);
    ticks(1);
    rx = 1'b1;
    ticks(6);
    chk("glitch_act_tH", RX_active, 1);
    ticks(1);
    chk("glitch_act_tH1", RX_active, 0);
    chk("glitch_time", cyc - t0, 11);
    idle(20);
    check_frames("glitch");

    send(8'h55, 1'b0, 1'b1, -1);
    send(8'hAA, 1'b0, 1'b1, -1);
    idle(20);
    if (obs_q.size() == 2) chk("b2b_gap", obs_q[1].at - obs_q[0].at, 11 * N);
    check_frames("b2b");

    send(8'hF1, 1'b1, 1'b1, 5);
    idle(20);
    check_frames("rst_abort");
    send(8'hC3, 1'b0, 1'b1, -1);
    idle(10);
    check_frames("after_rst");

    prev_stop = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bp  = ($urandom % 4) == 0;
      bs  = ($urandom % 4) == 0;
      d   = 8'($urandom);
      gap = int'($urandom_range(10, prev_stop ? 0 : 1));
      if (gap > 0) idle(gap);
      send(d, (^d) ^ bp, ~bs, -1);
      prev_stop = ~bs;
    end
    idle(20);
    check_frames("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
